// File: rtl/axi_mp_bridge_if.sv
// Signal bundle between the request ports / AXI3 slave side and axi_mp_bridge.
// The bridge connects through 'master'; the environment (ports + AXI slave) uses 'slave'.
interface axi_mp_bridge_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 3
);
    logic [NUM_PORTS-1:0]        p_req;
    logic [NUM_PORTS-1:0]        p_wr;
    logic [2*NUM_PORTS-1:0]      p_size;
    logic [LEN_W*NUM_PORTS-1:0]  p_len;
    logic [ADDR_W*NUM_PORTS-1:0] p_addr;
    logic [DATA_W*NUM_PORTS-1:0] p_wdata;
    logic [NUM_PORTS-1:0]        p_addr_ok;
    logic [NUM_PORTS-1:0]        p_data_ok;
    logic [DATA_W-1:0]           p_rdata;
    logic                        p_rlast;
    logic                        err;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  p_req, p_wr, p_size, p_len, p_addr, p_wdata,
        output p_addr_ok, p_data_ok, p_rdata, p_rlast, err,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output p_req, p_wr, p_size, p_len, p_addr, p_wdata,
        input  p_addr_ok, p_data_ok, p_rdata, p_rlast, err,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_mp_bridge.sv
// Multi-port SRAM-like to AXI3 master bridge: round-robin arbitration, one
// outstanding transaction, INCR read bursts, single-beat writes with byte strobes.
module axi_mp_bridge #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    axi_mp_bridge_if.master bus
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW_W,
        S_B
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [PTR_W-1:0]  r_rrPtr;
    logic [PTR_W-1:0]  r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_wdata;
    logic              r_awDone;
    logic              r_wDone;
    logic              r_err;

    logic                 w_grantValid;
    logic [PTR_W-1:0]     w_grantIdx;
    logic [PTR_W:0]       w_dist;
    logic [PTR_W:0]       w_bestDist;
    logic                 w_grantWr;
    logic [1:0]           w_grantSize;
    logic [LEN_W-1:0]     w_grantLen;
    logic [ADDR_W-1:0]    w_grantAddr;
    logic [DATA_W-1:0]    w_grantWdata;
    logic [NUM_PORTS-1:0] w_grantHot;
    logic [NUM_PORTS-1:0] w_ownerHot;
    logic                 w_awDoneNext;
    logic                 w_wDoneNext;
    logic [3:0]           w_wstrb;
    logic                 w_unused;

    // Pick the requester with the smallest circular distance from the rr pointer.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_dist       = '0;
        w_bestDist   = '0;
        w_grantWr    = 1'b0;
        w_grantSize  = '0;
        w_grantLen   = '0;
        w_grantAddr  = '0;
        w_grantWdata = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (PTR_W'(j) >= r_rrPtr) begin
                w_dist = {1'b0, PTR_W'(j)} - {1'b0, r_rrPtr};
            end else begin
                w_dist = {1'b0, PTR_W'(j)} + (PTR_W+1)'(NUM_PORTS) - {1'b0, r_rrPtr};
            end
            if (bus.p_req[j] && (!w_grantValid || (w_dist < w_bestDist))) begin
                w_grantValid = 1'b1;
                w_bestDist   = w_dist;
                w_grantIdx   = PTR_W'(j);
                w_grantWr    = bus.p_wr[j];
                w_grantSize  = bus.p_size[2*j +: 2];
                w_grantLen   = bus.p_len[LEN_W*j +: LEN_W];
                w_grantAddr  = bus.p_addr[ADDR_W*j +: ADDR_W];
                w_grantWdata = bus.p_wdata[DATA_W*j +: DATA_W];
            end
        end
    end

    always_comb begin
        w_grantHot = '0;
        w_ownerHot = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_grantHot[j] = (w_grantIdx == PTR_W'(j));
            w_ownerHot[j] = (r_owner == PTR_W'(j));
        end
    end

    always_comb begin
        w_wstrb = 4'b0000;
        if (r_state == S_AW_W) begin
            case (r_size)
                2'd0:    w_wstrb = 4'b0001 << r_addr[1:0];
                2'd1:    w_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
                default: w_wstrb = 4'b1111;
            endcase
        end
    end

    // Handshake outputs are gated while reset is high so nothing leaks from a dying transaction.
    always_comb begin
        w_nextState   = r_state;
        w_awDoneNext  = r_awDone;
        w_wDoneNext   = r_wDone;
        bus.p_addr_ok = '0;
        bus.p_data_ok = '0;
        bus.p_rdata   = '0;
        bus.p_rlast   = 1'b0;
        bus.arvalid   = 1'b0;
        bus.rready    = 1'b0;
        bus.awvalid   = 1'b0;
        bus.wvalid    = 1'b0;
        bus.bready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grantValid) begin
                    bus.p_addr_ok = w_grantHot;
                    w_nextState   = w_grantWr ? S_AW_W : S_AR;
                end
            end
            S_AR: begin
                bus.arvalid = 1'b1;
                if (bus.arready) begin
                    w_nextState = S_R;
                end
            end
            S_R: begin
                bus.rready = 1'b1;
                if (bus.rvalid) begin
                    bus.p_data_ok = w_ownerHot;
                    bus.p_rdata   = bus.rdata;
                    bus.p_rlast   = bus.rlast;
                    if (bus.rlast) begin
                        w_nextState = S_IDLE;
                    end
                end
            end
            S_AW_W: begin
                bus.awvalid = !r_awDone;
                bus.wvalid  = !r_wDone;
                if (bus.awready && !r_awDone) begin
                    w_awDoneNext = 1'b1;
                end
                if (bus.wready && !r_wDone) begin
                    w_wDoneNext = 1'b1;
                end
                if (w_awDoneNext && w_wDoneNext) begin
                    w_nextState  = S_B;
                    w_awDoneNext = 1'b0;
                    w_wDoneNext  = 1'b0;
                end
            end
            S_B: begin
                bus.bready = 1'b1;
                if (bus.bvalid) begin
                    bus.p_data_ok = w_ownerHot;
                    w_nextState   = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
        if (i_rst) begin
            bus.p_addr_ok = '0;
            bus.p_data_ok = '0;
            bus.p_rdata   = '0;
            bus.p_rlast   = 1'b0;
            bus.arvalid   = 1'b0;
            bus.rready    = 1'b0;
            bus.awvalid   = 1'b0;
            bus.wvalid    = 1'b0;
            bus.bready    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_rrPtr  <= '0;
            r_owner  <= '0;
            r_addr   <= '0;
            r_size   <= '0;
            r_len    <= '0;
            r_wdata  <= '0;
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_awDone <= w_awDoneNext;
            r_wDone  <= w_wDoneNext;
            if ((r_state == S_IDLE) && w_grantValid) begin
                r_owner <= w_grantIdx;
                r_addr  <= w_grantAddr;
                r_size  <= w_grantSize;
                r_len   <= w_grantLen;
                r_wdata <= w_grantWdata;
                r_rrPtr <= (w_grantIdx == PTR_W'(NUM_PORTS - 1)) ? '0 : w_grantIdx + PTR_W'(1);
            end
            if ((bus.rvalid && bus.rready && (bus.rresp != 2'b00)) ||
                (bus.bvalid && bus.bready && (bus.bresp != 2'b00))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.arid    = ID_W'(r_owner);
    assign bus.araddr  = r_addr;
    assign bus.arlen   = 8'(r_len);
    assign bus.arsize  = {1'b0, r_size};
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'b0000;
    assign bus.arprot  = 3'b000;

    assign bus.awid    = ID_W'(r_owner);
    assign bus.awaddr  = r_addr;
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = {1'b0, r_size};
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'b00;
    assign bus.awcache = 4'b0000;
    assign bus.awprot  = 3'b000;

    assign bus.wid     = ID_W'(r_owner);
    assign bus.wdata   = r_wdata;
    assign bus.wstrb   = w_wstrb;
    assign bus.wlast   = 1'b1;
    assign bus.err     = r_err;

    // Response ids are not needed with a single outstanding transaction.
    assign w_unused = ^{bus.rid, bus.bid};
endmodule

// File: tb/tb_axi_mp_bridge.sv
// Self-checking bench for axi_mp_bridge: vector table of single transactions,
// hand-written reset, mid-burst reset and round-robin sequences, data_ok scoreboard.
module tb_axi_mp_bridge;
    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int LW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    axi_mp_bridge_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) bus ();

    axi_mp_bridge #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int          port;
        bit          wr;
        logic [1:0]  size;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] data;
        int          arDelay;
        bit          wFirst;
        logic [1:0]  resp;
        logic [3:0]  expStrb;
        bit          expErr;
    } vec_t;

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] data;
        bit          last;
    } sb_t;

    vec_t vecs[8];
    sb_t  sbq[$];
    int   checkCount = 0;
    int   errorCount = 0;

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] h;
        h = '0;
        h[p] = 1'b1;
        return h;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every data_ok pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        sb_t e;
        if (bus.p_data_ok !== '0) begin
            if (sbq.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected_data_ok: got %b, expected none", bus.p_data_ok);
            end else begin
                e = sbq.pop_front();
                checkOutput("data_ok_port", 64'(bus.p_data_ok), 64'(onehot(e.port)));
                if (!e.wr) begin
                    checkOutput("rdata", 64'(bus.p_rdata), 64'(e.data));
                    checkOutput("rlast", 64'(bus.p_rlast), 64'(e.last));
                end
            end
        end
    end

    task automatic driveReq(input vec_t v);
        bus.p_req[v.port]           = 1'b1;
        bus.p_wr[v.port]            = v.wr;
        bus.p_size[2*v.port +: 2]   = v.size;
        bus.p_len[3*v.port +: 3]    = v.len;
        bus.p_addr[32*v.port +: 32] = v.addr;
        bus.p_wdata[32*v.port +: 32] = v.data;
    endtask

    task automatic waitAddrOk(input int port, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.p_addr_ok != '0) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL addr_ok_timeout: got none after 20 cycles, expected port %0d", port);
        end
    endtask

    task automatic serveRead(input vec_t v);
        bus.rid = IW'(v.port);
        for (int c = 0; c < v.arDelay; c++) begin
            bus.arready = 1'b0;
            @(negedge clk);
            checkOutput("arvalid_hold", 64'(bus.arvalid), 64'd1);
            checkOutput("araddr_hold", 64'(bus.araddr), 64'(v.addr));
            step();
        end
        bus.arready = 1'b1;
        @(negedge clk);
        checkOutput("arvalid", 64'(bus.arvalid), 64'd1);
        checkOutput("araddr", 64'(bus.araddr), 64'(v.addr));
        checkOutput("arlen", 64'(bus.arlen), 64'(v.len));
        checkOutput("arsize", 64'(bus.arsize), 64'(v.size));
        checkOutput("arid", 64'(bus.arid), 64'(v.port));
        checkOutput("arburst", 64'(bus.arburst), 64'd1);
        step();
        bus.arready = 1'b0;
        for (int b = 0; b <= int'(v.len); b++) begin
            bus.rvalid = 1'b1;
            bus.rdata  = v.data + 32'(b);
            bus.rlast  = (b == int'(v.len));
            bus.rresp  = v.resp;
            @(negedge clk);
            checkOutput("rready", 64'(bus.rready), 64'd1);
            step();
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
        @(negedge clk);
        checkOutput("rready_idle", 64'(bus.rready), 64'd0);
        checkOutput("arvalid_idle", 64'(bus.arvalid), 64'd0);
        step();
    endtask

    task automatic serveWrite(input vec_t v);
        bus.wready  = v.wFirst;
        bus.awready = !v.wFirst;
        @(negedge clk);
        checkOutput("awvalid", 64'(bus.awvalid), 64'd1);
        checkOutput("wvalid", 64'(bus.wvalid), 64'd1);
        checkOutput("awaddr", 64'(bus.awaddr), 64'(v.addr));
        checkOutput("awlen", 64'(bus.awlen), 64'd0);
        checkOutput("awsize", 64'(bus.awsize), 64'(v.size));
        checkOutput("awid", 64'(bus.awid), 64'(v.port));
        checkOutput("wstrb", 64'(bus.wstrb), 64'(v.expStrb));
        checkOutput("wdata", 64'(bus.wdata), 64'(v.data));
        checkOutput("wlast", 64'(bus.wlast), 64'd1);
        step();
        bus.wready  = !v.wFirst;
        bus.awready = v.wFirst;
        @(negedge clk);
        checkOutput("awvalid_2nd", 64'(bus.awvalid), 64'(v.wFirst));
        checkOutput("wvalid_2nd", 64'(bus.wvalid), 64'(!v.wFirst));
        step();
        bus.wready  = 1'b0;
        bus.awready = 1'b0;
        bus.bid     = IW'(v.port);
        bus.bvalid  = 1'b1;
        bus.bresp   = v.resp;
        @(negedge clk);
        checkOutput("bready", 64'(bus.bready), 64'd1);
        step();
        bus.bvalid = 1'b0;
        bus.bresp  = 2'b00;
        @(negedge clk);
        checkOutput("bready_idle", 64'(bus.bready), 64'd0);
        step();
    endtask

    task automatic applyStimulus(input vec_t v);
        bit seen;
        driveReq(v);
        waitAddrOk(v.port, seen);
        if (!seen) begin
            bus.p_req = '0;
            return;
        end
        checkOutput("addr_ok", 64'(bus.p_addr_ok), 64'(onehot(v.port)));
        if (v.wr) begin
            sbq.push_back('{v.port, 1'b1, 32'h0, 1'b0});
        end else begin
            for (int b = 0; b <= int'(v.len); b++) begin
                sbq.push_back('{v.port, 1'b0, v.data + 32'(b), (b == int'(v.len))});
            end
        end
        step();
        bus.p_req = '0;
        if (v.wr) begin
            serveWrite(v);
        end else begin
            serveRead(v);
        end
        @(negedge clk);
        checkOutput("err", 64'(bus.err), 64'(v.expErr));
        step();
    endtask

    task automatic resetMidBurst();
        vec_t v;
        bit   seen;
        v = '{0, 1'b0, 2'd2, 3'd7, 32'h0000_3000, 32'h7000_0000, 0, 1'b0, 2'b00, 4'h0, 1'b0};
        driveReq(v);
        waitAddrOk(0, seen);
        if (!seen) begin
            bus.p_req = '0;
            return;
        end
        checkOutput("mid_addr_ok", 64'(bus.p_addr_ok), 64'(onehot(0)));
        for (int b = 0; b < 3; b++) begin
            sbq.push_back('{0, 1'b0, v.data + 32'(b), 1'b0});
        end
        step();
        bus.p_req   = '0;
        bus.arready = 1'b1;
        @(negedge clk);
        checkOutput("mid_arlen", 64'(bus.arlen), 64'd7);
        step();
        bus.arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.rvalid = 1'b1;
            bus.rdata  = v.data + 32'(b);
            bus.rlast  = 1'b0;
            @(negedge clk);
            step();
        end
        rst        = 1'b1;
        bus.rdata  = v.data + 32'd3;
        @(negedge clk);
        checkOutput("data_ok_during_rst", 64'(bus.p_data_ok), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rready_after_rst", 64'(bus.rready), 64'd0);
        checkOutput("data_ok_after_rst", 64'(bus.p_data_ok), 64'd0);
        checkOutput("arvalid_after_rst", 64'(bus.arvalid), 64'd0);
        checkOutput("err_after_rst", 64'(bus.err), 64'd0);
        step();
        bus.rvalid = 1'b0;
    endtask

    task automatic roundRobin();
        int  expGrant[4];
        bit  seen;
        expGrant = '{0, 1, 0, 1};
        bus.p_wr              = '0;
        bus.p_size            = {2'd2, 2'd2};
        bus.p_len             = '0;
        bus.p_addr[31:0]      = 32'h0000_1000;
        bus.p_addr[63:32]     = 32'h0000_2000;
        bus.p_req             = 2'b11;
        for (int t = 0; t < 4; t++) begin
            waitAddrOk(expGrant[t], seen);
            if (!seen) break;
            checkOutput("rr_grant", 64'(bus.p_addr_ok), 64'(onehot(expGrant[t])));
            sbq.push_back('{expGrant[t], 1'b0, 32'h9000 + 32'(t), 1'b1});
            step();
            if (t == 3) bus.p_req = '0;
            bus.arready = 1'b1;
            @(negedge clk);
            checkOutput("rr_arid", 64'(bus.arid), 64'(expGrant[t]));
            checkOutput("rr_araddr", 64'(bus.araddr), (expGrant[t] == 0) ? 64'h1000 : 64'h2000);
            step();
            bus.arready = 1'b0;
            bus.rvalid  = 1'b1;
            bus.rdata   = 32'h9000 + 32'(t);
            bus.rlast   = 1'b1;
            @(negedge clk);
            step();
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
        end
        bus.p_req = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b0, 2'd2, 3'd0, 32'h0000_0100, 32'hDEAD_BEEF, 1, 1'b0, 2'b00, 4'h0,    1'b0};
        vecs[1] = '{1, 1'b0, 2'd2, 3'd7, 32'h1FC0_0000, 32'h1111_0000, 0, 1'b0, 2'b00, 4'h0,    1'b0};
        vecs[2] = '{0, 1'b1, 2'd0, 3'd0, 32'h0000_0203, 32'hAB00_0000, 0, 1'b1, 2'b00, 4'b1000, 1'b0};
        vecs[3] = '{1, 1'b1, 2'd1, 3'd0, 32'h0000_0202, 32'h1234_0000, 0, 1'b0, 2'b00, 4'b1100, 1'b0};
        vecs[4] = '{0, 1'b1, 2'd1, 3'd0, 32'h0000_0100, 32'h0000_5678, 0, 1'b1, 2'b00, 4'b0011, 1'b0};
        vecs[5] = '{1, 1'b1, 2'd0, 3'd0, 32'h0000_0001, 32'h0000_CD00, 0, 1'b0, 2'b00, 4'b0010, 1'b0};
        vecs[6] = '{0, 1'b1, 2'd2, 3'd0, 32'h0000_0400, 32'hCAFE_F00D, 0, 1'b1, 2'b10, 4'b1111, 1'b1};
        vecs[7] = '{1, 1'b0, 2'd2, 3'd0, 32'h0000_0800, 32'h55AA_55AA, 2, 1'b0, 2'b00, 4'h0,    1'b1};

        bus.p_req   = 2'b11;
        bus.p_wr    = '0;
        bus.p_size  = '0;
        bus.p_len   = '0;
        bus.p_addr  = '0;
        bus.p_wdata = '0;
        bus.arready = 1'b0;
        bus.rid     = '0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b0;
        bus.rvalid  = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bid     = '0;
        bus.bresp   = 2'b00;
        bus.bvalid  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_addr_ok", 64'(bus.p_addr_ok), 64'd0);
        checkOutput("rst_data_ok", 64'(bus.p_data_ok), 64'd0);
        checkOutput("rst_arvalid", 64'(bus.arvalid), 64'd0);
        checkOutput("rst_awvalid", 64'(bus.awvalid), 64'd0);
        checkOutput("rst_wvalid", 64'(bus.wvalid), 64'd0);
        checkOutput("rst_rready", 64'(bus.rready), 64'd0);
        checkOutput("rst_bready", 64'(bus.bready), 64'd0);
        checkOutput("rst_err", 64'(bus.err), 64'd0);
        checkOutput("rst_arid", 64'(bus.arid), 64'd0);
        checkOutput("rst_araddr", 64'(bus.araddr), 64'd0);
        checkOutput("rst_arlen", 64'(bus.arlen), 64'd0);
        step();
        bus.p_req = '0;
        rst       = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        resetMidBurst();
        roundRobin();

        @(negedge clk);
        checkOutput("sb_drain", 64'(sbq.size()), 64'd0);
        checkOutput("final_err", 64'(bus.err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
